// File: rtl/fpu_pkg.sv
// Shared definitions for the single-precision operand decoder: FSM encoding,
// class-flag bit positions, exponent bias and default field widths.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLASS = 2'd1,
        ST_NORM  = 2'd2,
        ST_DONE  = 2'd3
    } fpu_state_t;

    localparam int CLS_NAN  = 3;
    localparam int CLS_INF  = 2;
    localparam int CLS_ZERO = 1;
    localparam int CLS_DEN  = 0;

    localparam int FP_BIAS   = 127;
    localparam int EXP_W_DEF = 10;
    localparam int MAN_W_DEF = 24;

endpackage

// File: rtl/fpu_decode_if.sv
// Controller <-> decoder bundle: request/operands one way, ready and decoded
// sign/exponent/mantissa/class fields for both operands the other way.
interface fpu_decode_if #(
    parameter int EXP_W = fpu_pkg::EXP_W_DEF,
    parameter int MAN_W = fpu_pkg::MAN_W_DEF
);
    logic                    fpu_dec_en_i;
    logic [31:0]             fpu_opa_i;
    logic [31:0]             fpu_opb_i;
    logic                    fpu_dec_ready_o;
    logic                    fpu_a_sgn_o;
    logic                    fpu_b_sgn_o;
    logic signed [EXP_W-1:0] fpu_a_exp_o;
    logic signed [EXP_W-1:0] fpu_b_exp_o;
    logic [MAN_W-1:0]        fpu_a_man_o;
    logic [MAN_W-1:0]        fpu_b_man_o;
    logic [3:0]              fpu_a_cls_o;
    logic [3:0]              fpu_b_cls_o;

    modport master (
        output fpu_dec_en_i, fpu_opa_i, fpu_opb_i,
        input  fpu_dec_ready_o, fpu_a_sgn_o, fpu_b_sgn_o, fpu_a_exp_o, fpu_b_exp_o,
               fpu_a_man_o, fpu_b_man_o, fpu_a_cls_o, fpu_b_cls_o
    );

    modport slave (
        input  fpu_dec_en_i, fpu_opa_i, fpu_opb_i,
        output fpu_dec_ready_o, fpu_a_sgn_o, fpu_b_sgn_o, fpu_a_exp_o, fpu_b_exp_o,
               fpu_a_man_o, fpu_b_man_o, fpu_a_cls_o, fpu_b_cls_o
    );
endinterface

// File: rtl/fpu_dec_unpack.sv
// Combinational classify/unpack of one IEEE-754 single operand.
// FPU_DEC_NORM_EN: denormals are passed on for normalization instead of flushed.
module fpu_dec_unpack import fpu_pkg::*; #(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic [31:0]             i_op,
    output logic                    o_sgn,
    output logic signed [EXP_W-1:0] o_exp,
    output logic [MAN_W-1:0]        o_man,
`ifdef FPU_DEC_NORM_EN
    output logic                    o_denorm,
`endif
    output logic [3:0]              o_cls
);

    logic [7:0]  w_e;
    logic [22:0] w_f;

    assign w_e   = i_op[30:23];
    assign w_f   = i_op[22:0];
    assign o_sgn = i_op[31];

    // Hidden bit plus fraction, placed at the top of the mantissa field.
    function automatic logic [MAN_W-1:0] align_man(input logic [23:0] m);
        return MAN_W'(m) << (MAN_W - 24);
    endfunction

    always_comb begin
        o_exp = '0;
        o_man = '0;
        o_cls = '0;
`ifdef FPU_DEC_NORM_EN
        o_denorm = 1'b0;
`endif
        if (w_e == 8'hFF) begin
            if (w_f != '0) begin
                o_cls[CLS_NAN] = 1'b1;
                o_man          = align_man({1'b0, w_f});
            end else begin
                o_cls[CLS_INF] = 1'b1;
            end
        end else if (w_e == 8'h00) begin
            if (w_f == '0) begin
                o_cls[CLS_ZERO] = 1'b1;
            end else begin
`ifdef FPU_DEC_NORM_EN
                o_cls[CLS_DEN] = 1'b1;
                o_exp          = EXP_W'(1 - FP_BIAS);
                o_man          = align_man({1'b0, w_f});
                o_denorm       = 1'b1;
`else
                o_cls[CLS_ZERO] = 1'b1;
                o_cls[CLS_DEN]  = 1'b1;
`endif
            end
        end else begin
            o_exp = EXP_W'($signed({24'd0, w_e}) - FP_BIAS);
            o_man = align_man({1'b1, w_f});
        end
    end

endmodule

// File: rtl/fpu_decode.sv
// Two-operand IEEE-754 single decoder: capture, classify, optional denormal
// normalization (FPU_DEC_NORM_EN), then hold the fields while the request stays high.
module fpu_decode import fpu_pkg::*; #(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic         fpu_clk,
    input  logic         fpu_rst_n,
    fpu_decode_if.slave  dec_bus
);

    fpu_state_t              r_state;
    fpu_state_t              w_next;
    logic                    w_en;
    logic [31:0]             r_opa;
    logic [31:0]             r_opb;
    logic                    r_a_sgn;
    logic                    r_b_sgn;
    logic signed [EXP_W-1:0] r_a_exp;
    logic signed [EXP_W-1:0] r_b_exp;
    logic [MAN_W-1:0]        r_a_man;
    logic [MAN_W-1:0]        r_b_man;
    logic [3:0]              r_a_cls;
    logic [3:0]              r_b_cls;
    logic                    w_a_sgn;
    logic                    w_b_sgn;
    logic signed [EXP_W-1:0] w_a_exp;
    logic signed [EXP_W-1:0] w_b_exp;
    logic [MAN_W-1:0]        w_a_man;
    logic [MAN_W-1:0]        w_b_man;
    logic [3:0]              w_a_cls;
    logic [3:0]              w_b_cls;

    assign w_en = dec_bus.fpu_dec_en_i;

`ifdef FPU_DEC_NORM_EN
    localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    logic w_a_den, w_b_den;
    logic r_a_nrm, r_b_nrm;
    logic w_a_sh, w_b_sh, w_norm_done;

    // Only denormal operands are shifted; zero/NaN mantissas keep their MSB at 0.
    always_comb begin
        w_a_sh      = r_a_nrm && !r_a_man[MAN_W-1];
        w_b_sh      = r_b_nrm && !r_b_man[MAN_W-1];
        w_norm_done = (!r_a_nrm || r_a_man[MAN_W-1] || r_a_man[MAN_W-2]) &&
                      (!r_b_nrm || r_b_man[MAN_W-1] || r_b_man[MAN_W-2]);
    end
`endif

    fpu_dec_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .i_op     (r_opa),
        .o_sgn    (w_a_sgn),
        .o_exp    (w_a_exp),
        .o_man    (w_a_man),
`ifdef FPU_DEC_NORM_EN
        .o_denorm (w_a_den),
`endif
        .o_cls    (w_a_cls)
    );

    fpu_dec_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .i_op     (r_opb),
        .o_sgn    (w_b_sgn),
        .o_exp    (w_b_exp),
        .o_man    (w_b_man),
`ifdef FPU_DEC_NORM_EN
        .o_denorm (w_b_den),
`endif
        .o_cls    (w_b_cls)
    );

    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_en) w_next = ST_CLASS;
            end
            ST_CLASS: begin
                if (!w_en) begin
                    w_next = ST_IDLE;
                end else begin
`ifdef FPU_DEC_NORM_EN
                    w_next = (w_a_den || w_b_den) ? ST_NORM : ST_DONE;
`else
                    w_next = ST_DONE;
`endif
                end
            end
            ST_NORM: begin
`ifdef FPU_DEC_NORM_EN
                if (!w_en)            w_next = ST_IDLE;
                else if (w_norm_done) w_next = ST_DONE;
`else
                w_next = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (!w_en) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_a_sgn <= 1'b0;
            r_b_sgn <= 1'b0;
            r_a_exp <= '0;
            r_b_exp <= '0;
            r_a_man <= '0;
            r_b_man <= '0;
            r_a_cls <= '0;
            r_b_cls <= '0;
`ifdef FPU_DEC_NORM_EN
            r_a_nrm <= 1'b0;
            r_b_nrm <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_en) begin
                        r_opa <= dec_bus.fpu_opa_i;
                        r_opb <= dec_bus.fpu_opb_i;
                    end
                end
                ST_CLASS: begin
                    if (w_en) begin
                        r_a_sgn <= w_a_sgn;
                        r_b_sgn <= w_b_sgn;
                        r_a_exp <= w_a_exp;
                        r_b_exp <= w_b_exp;
                        r_a_man <= w_a_man;
                        r_b_man <= w_b_man;
                        r_a_cls <= w_a_cls;
                        r_b_cls <= w_b_cls;
`ifdef FPU_DEC_NORM_EN
                        r_a_nrm <= w_a_den;
                        r_b_nrm <= w_b_den;
`endif
                    end
                end
`ifdef FPU_DEC_NORM_EN
                ST_NORM: begin
                    if (w_en) begin
                        if (w_a_sh) begin
                            r_a_man <= r_a_man << 1;
                            r_a_exp <= r_a_exp - EXP_ONE;
                        end
                        if (w_b_sh) begin
                            r_b_man <= r_b_man << 1;
                            r_b_exp <= r_b_exp - EXP_ONE;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign dec_bus.fpu_dec_ready_o = (r_state == ST_DONE);
    assign dec_bus.fpu_a_sgn_o     = r_a_sgn;
    assign dec_bus.fpu_b_sgn_o     = r_b_sgn;
    assign dec_bus.fpu_a_exp_o     = r_a_exp;
    assign dec_bus.fpu_b_exp_o     = r_b_exp;
    assign dec_bus.fpu_a_man_o     = r_a_man;
    assign dec_bus.fpu_b_man_o     = r_b_man;
    assign dec_bus.fpu_a_cls_o     = r_a_cls;
    assign dec_bus.fpu_b_cls_o     = r_b_cls;

endmodule

// File: tb/tb_fpu_decode.sv
// Table-driven scoreboard bench for fpu_decode; expectations follow FPU_DEC_NORM_EN.
module tb_fpu_decode;

    localparam int EXP_W = 10;
    localparam int MAN_W = 24;

`ifdef FPU_DEC_NORM_EN
    localparam bit NORM_ON = 1'b1;
`else
    localparam bit NORM_ON = 1'b0;
`endif

    logic fpu_clk   = 1'b0;
    logic fpu_rst_n = 1'b0;

    always #5 fpu_clk = ~fpu_clk;

    fpu_decode_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fpu_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .fpu_clk   (fpu_clk),
        .fpu_rst_n (fpu_rst_n),
        .dec_bus   (bus)
    );

    typedef struct {
        logic [31:0] opa;
        logic [31:0] opb;
        int          lat;
        logic        a_sgn;
        logic [9:0]  a_exp;
        logic [23:0] a_man;
        logic [3:0]  a_cls;
        logic        b_sgn;
        logic [9:0]  b_exp;
        logic [23:0] b_man;
        logic [3:0]  b_cls;
    } vec_t;

    vec_t vecs[8];
    vec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mkv(
        input logic [31:0] opa, input logic [31:0] opb, input int lat,
        input logic a_sgn, input logic [9:0] a_exp, input logic [23:0] a_man, input logic [3:0] a_cls,
        input logic b_sgn, input logic [9:0] b_exp, input logic [23:0] b_man, input logic [3:0] b_cls);
        vec_t v;
        v.opa = opa; v.opb = opb; v.lat = lat;
        v.a_sgn = a_sgn; v.a_exp = a_exp; v.a_man = a_man; v.a_cls = a_cls;
        v.b_sgn = b_sgn; v.b_exp = b_exp; v.b_man = b_man; v.b_cls = b_cls;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic check_fields(input vec_t e, input string tag);
        chk({tag, ".a_sgn"}, 32'(bus.fpu_a_sgn_o), 32'(e.a_sgn));
        chk({tag, ".a_exp"}, 32'(unsigned'(bus.fpu_a_exp_o)), 32'(e.a_exp));
        chk({tag, ".a_man"}, 32'(bus.fpu_a_man_o), 32'(e.a_man));
        chk({tag, ".a_cls"}, 32'(bus.fpu_a_cls_o), 32'(e.a_cls));
        chk({tag, ".b_sgn"}, 32'(bus.fpu_b_sgn_o), 32'(e.b_sgn));
        chk({tag, ".b_exp"}, 32'(unsigned'(bus.fpu_b_exp_o)), 32'(e.b_exp));
        chk({tag, ".b_man"}, 32'(bus.fpu_b_man_o), 32'(e.b_man));
        chk({tag, ".b_cls"}, 32'(bus.fpu_b_cls_o), 32'(e.b_cls));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ready"}, 32'(bus.fpu_dec_ready_o), 32'd0);
        check_fields(mkv(32'd0, 32'd0, 0, 1'b0, 10'd0, 24'd0, 4'd0, 1'b0, 10'd0, 24'd0, 4'd0), tag);
    endtask

    // Drive a request, wait (bounded) for ready, then compare against the queued expectation.
    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        int   n;
        bit   got;
        @(negedge fpu_clk);
        bus.fpu_opa_i    = v.opa;
        bus.fpu_opb_i    = v.opb;
        bus.fpu_dec_en_i = 1'b1;
        sb_q.push_back(v);
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(posedge fpu_clk);
            n++;
            #1;
            if (bus.fpu_dec_ready_o === 1'b1) got = 1'b1;
        end
        e = sb_q.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: no ready after %0d edges, expected at edge %0d", tag, n, e.lat);
        end else begin
            chk({tag, ".latency"}, 32'(n), 32'(e.lat));
            check_fields(e, tag);
        end
    endtask

    task automatic release_en(input vec_t e, input string tag);
        @(negedge fpu_clk);
        bus.fpu_dec_en_i = 1'b0;
        @(posedge fpu_clk);
        #1;
        chk({tag, ".idle_ready"}, 32'(bus.fpu_dec_ready_o), 32'd0);
        chk({tag, ".idle_a_man"}, 32'(bus.fpu_a_man_o), 32'(e.a_man));
        chk({tag, ".idle_b_cls"}, 32'(bus.fpu_b_cls_o), 32'(e.b_cls));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vec_t v3;

        vecs[0] = mkv(32'h3F800000, 32'hC0000000, 2,
                      1'b0, 10'h000, 24'h800000, 4'b0000, 1'b1, 10'h001, 24'h800000, 4'b0000);
        vecs[1] = mkv(32'h7F800000, 32'h7FC00000, 2,
                      1'b0, 10'h000, 24'h000000, 4'b0100, 1'b0, 10'h000, 24'h400000, 4'b1000);
        vecs[2] = mkv(32'h00000000, 32'h80000000, 2,
                      1'b0, 10'h000, 24'h000000, 4'b0010, 1'b1, 10'h000, 24'h000000, 4'b0010);
        vecs[3] = mkv(32'h7F7FFFFF, 32'h00800000, 2,
                      1'b0, 10'h07F, 24'hFFFFFF, 4'b0000, 1'b0, 10'h382, 24'h800000, 4'b0000);
        if (NORM_ON) begin
            vecs[4] = mkv(32'h00000001, 32'h3F800000, 25,
                          1'b0, 10'h36B, 24'h800000, 4'b0001, 1'b0, 10'h000, 24'h800000, 4'b0000);
            vecs[5] = mkv(32'h80400000, 32'h00000003, 24,
                          1'b1, 10'h381, 24'h800000, 4'b0001, 1'b0, 10'h36C, 24'hC00000, 4'b0001);
        end else begin
            vecs[4] = mkv(32'h00000001, 32'h3F800000, 2,
                          1'b0, 10'h000, 24'h000000, 4'b0011, 1'b0, 10'h000, 24'h800000, 4'b0000);
            vecs[5] = mkv(32'h80400000, 32'h00000003, 2,
                          1'b1, 10'h000, 24'h000000, 4'b0011, 1'b0, 10'h000, 24'h000000, 4'b0011);
        end
        vecs[6] = mkv(32'h40400000, 32'hBF000000, 2,
                      1'b0, 10'h001, 24'hC00000, 4'b0000, 1'b1, 10'h3FF, 24'h800000, 4'b0000);
        vecs[7] = mkv(32'hFFFFFFFF, 32'h00000000, 2,
                      1'b1, 10'h000, 24'h7FFFFF, 4'b1000, 1'b0, 10'h000, 24'h000000, 4'b0010);

        bus.fpu_dec_en_i = 1'b0;
        bus.fpu_opa_i    = 32'hDEADBEEF;
        bus.fpu_opb_i    = 32'h12345678;
        repeat (2) @(posedge fpu_clk);
        #1;
        chk_zero("reset");
        @(negedge fpu_clk);
        fpu_rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                // Hold the request while the operand inputs wander; fields must not move.
                for (int k = 0; k < 10; k++) begin
                    @(negedge fpu_clk);
                    bus.fpu_opa_i = $urandom;
                    bus.fpu_opb_i = $urandom;
                    @(posedge fpu_clk);
                    #1;
                    chk($sformatf("hold%0d.ready", k), 32'(bus.fpu_dec_ready_o), 32'd1);
                    chk($sformatf("hold%0d.a_man", k), 32'(bus.fpu_a_man_o), 32'(vecs[0].a_man));
                    chk($sformatf("hold%0d.b_exp", k), 32'(unsigned'(bus.fpu_b_exp_o)), 32'(vecs[0].b_exp));
                end
            end
            release_en(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort: drop the request mid-operation; ready must never rise.
        @(negedge fpu_clk);
        bus.fpu_opa_i    = 32'h00000001;
        bus.fpu_opb_i    = 32'h3F800000;
        bus.fpu_dec_en_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < (NORM_ON ? 5 : 1); k++) begin
            @(posedge fpu_clk);
            #1;
            seen = seen | bus.fpu_dec_ready_o;
        end
        @(negedge fpu_clk);
        bus.fpu_dec_en_i = 1'b0;
        repeat (2) begin
            @(posedge fpu_clk);
            #1;
            seen = seen | bus.fpu_dec_ready_o;
        end
        chk("abort.ready_seen", 32'(seen), 32'd0);
        v3 = mkv(32'h40400000, 32'h3F800000, 2,
                 1'b0, 10'h001, 24'hC00000, 4'b0000, 1'b0, 10'h000, 24'h800000, 4'b0000);
        run_vec(v3, "after_abort");
        release_en(v3, "after_abort");

        // Asynchronous reset off the clock edge, mid-normalization when enabled.
        @(negedge fpu_clk);
        bus.fpu_opa_i    = 32'h00000001;
        bus.fpu_opb_i    = 32'h3F800000;
        bus.fpu_dec_en_i = 1'b1;
        repeat (NORM_ON ? 6 : 2) @(posedge fpu_clk);
        #3;
        fpu_rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        bus.fpu_dec_en_i = 1'b0;
        @(negedge fpu_clk);
        fpu_rst_n = 1'b1;
        repeat (3) @(posedge fpu_clk);
        #1;
        chk("post_rst.idle_ready", 32'(bus.fpu_dec_ready_o), 32'd0);
        run_vec(vecs[6], "post_rst");
        release_en(vecs[6], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
